// File: rtl/rr_grant_gen.sv
// rr_grant_gen -- round-robin grant generator for a WIDTH-requester arbiter.
//
// Samples req while idle, picks the first requester above the last completed
// grant (wrapping), and presents a registered one-hot grant with a load
// strobe. Both are held until the downstream grant register samples ack.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-low reset
//   req     in   [WIDTH-1:0] request vector
//   ack     in   downstream accepted the current grant
//   grant   out  [WIDTH-1:0] registered one-hot grant, zero when none
//   load    out  high exactly while a grant is outstanding
//   timeout out  one-cycle pulse when a grant is abandoned
//
// Optional feature: define RR_GRANT_TIMEOUT_EN to abandon a grant that has
// not been acked within TIMEOUT cycles. Without it, timeout is tied to 0 and
// a grant waits for ack indefinitely.

module rr_grant_gen #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    output logic [WIDTH-1:0] grant,
    output logic             load,
    output logic             timeout
);

    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [WIDTH-1:0] grant_n;
    logic             load_n;
    logic [WIDTH-1:0] sel;
    logic             found;
    logic [PW-1:0]    idx;

    function automatic logic [PW-1:0] oh2idx(input logic [WIDTH-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (oh[i]) oh2idx = PW'(i);
    endfunction

    // Search starts just above ptr and wraps, so ptr itself is checked last.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= WIDTH; i++) begin
            idx = PW'((int'(ptr) + i) % WIDTH);
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          timeout_q, timeout_n;
`endif

    always_comb begin
        state_n = state;
        grant_n = grant;
        load_n  = load;
        ptr_n   = ptr;
`ifdef RR_GRANT_TIMEOUT_EN
        cnt_n     = cnt;
        timeout_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_n = sel;
                    load_n  = 1'b1;
                    state_n = WAIT;
`ifdef RR_GRANT_TIMEOUT_EN
                    cnt_n   = '0;
`endif
                end
            end
            WAIT: begin
                if (ack) begin
                    ptr_n   = oh2idx(grant);
                    grant_n = '0;
                    load_n  = 1'b0;
                    state_n = IDLE;
                end
`ifdef RR_GRANT_TIMEOUT_EN
                // Expire on the edge that would take the count to TIMEOUT;
                // the abandoned requester drops to lowest priority.
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    ptr_n     = oh2idx(grant);
                    grant_n   = '0;
                    load_n    = 1'b0;
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
`endif
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                load_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= '0;
            load  <= 1'b0;
            ptr   <= PW'(WIDTH - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            load  <= load_n;
            ptr   <= ptr_n;
        end
    end

`ifdef RR_GRANT_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            timeout_q <= timeout_n;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_gen.sv
// tb_rr_grant_gen -- directed self-checking bench for rr_grant_gen (WIDTH=4).
// Inputs change #1 after a rising edge; outputs are checked at that point,
// i.e. they reflect the edge just taken.

module tb_rr_grant_gen;

`ifdef RR_GRANT_TIMEOUT_EN
    localparam int TO = 3;
`else
    localparam int TO = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       ack = 1'b0;
    logic [3:0] grant;
    logic       load;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_grant_gen #(.WIDTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .grant(grant), .load(load), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = 4'b0000; ack = 1'b0;
        #12;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b want=0000", grant); end
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got=%b want=0", load); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        rst = 1'b1;
        step();
    endtask

    // req=1111 held, ack one cycle after each load rise.
    task automatic test_rotation();
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (grant !== exp_seq[k] || load !== 1'b1) begin errors++; $display("FAIL rot_grant%0d got=%b/%b want=%b/1", k, grant, load, exp_seq[k]); end
            ack = 1'b1;
            if (k == 4) req = 4'b0000;
            step();
            ack = 1'b0;
            checks++; if (grant !== 4'b0000 || load !== 1'b0) begin errors++; $display("FAIL rot_gap%0d got=%b/%b want=0000/0", k, grant, load); end
        end
    endtask

    // ptr=0 here: 1001 picks 3 first, then wraps to 0.
    task automatic test_wrap();
        req = 4'b1001;
        step();
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_first got=%b want=1000", grant); end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL wrap_gap load got=%b want=0", load); end
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL wrap_second got=%b want=0001", grant); end
        ack = 1'b1; req = 4'b0000; step(); ack = 1'b0;
    endtask

    // Grant stays put while ack is low no matter what req does.
    task automatic test_hold();
        logic [3:0] rq [6];
        rq = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        req = 4'b0010;
        step();
        for (int k = 0; k < 6; k++) begin
            req = rq[k];
            checks++; if (grant !== 4'b0010 || load !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL hold%0d got=%b/%b/%b want=0010/1/0", k, grant, load, timeout); end
            step();
        end
        ack = 1'b1; req = 4'b0000; step(); ack = 1'b0;
        checks++; if (grant !== 4'b0000 || load !== 1'b0) begin errors++; $display("FAIL hold_release got=%b/%b want=0000/0", grant, load); end
    endtask

    // ack in IDLE must do nothing; ptr stays 1 so 1111 would then give 0100.
    task automatic test_ack_idle();
        req = 4'b0000; ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (grant !== 4'b0000 || load !== 1'b0) begin errors++; $display("FAIL ack_idle%0d got=%b/%b want=0000/0", k, grant, load); end
        end
        ack = 1'b0; req = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100 || load !== 1'b1) begin errors++; $display("FAIL ack_idle_next got=%b/%b want=0100/1", grant, load); end
    endtask

    // Entered with 0100 outstanding and ptr=1; reset must also restore ptr.
    task automatic test_reset_mid_wait();
        req = 4'b0000;
        #2 rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || load !== 1'b0) begin errors++; $display("FAIL rst_wait got=%b/%b want=0000/0", grant, load); end
        #3 rst = 1'b1;
        req = 4'b1111;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rst_after got=%b want=0001", grant); end
        ack = 1'b1; req = 4'b0000; step(); ack = 1'b0;
    endtask

    // ptr=0: 0110 picks 1, then ptr=1 picks 2.
    task automatic test_back_to_back();
        req = 4'b0110;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL b2b_first got=%b want=0010", grant); end
        ack = 1'b1; step(); ack = 1'b0;
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL b2b_second got=%b want=0100", grant); end
        ack = 1'b1; req = 4'b0000; step(); ack = 1'b0;
    endtask

`ifdef RR_GRANT_TIMEOUT_EN
    task automatic test_timeout();
        rst = 1'b0; #3 rst = 1'b1;
        req = 4'b0001;
        step();
        req = 4'b0000;
        checks++; if (grant !== 4'b0001 || timeout !== 1'b0) begin errors++; $display("FAIL to_grant got=%b/%b want=0001/0", grant, timeout); end
        step(); step();
        checks++; if (load !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_pending got=%b/%b want=1/0", load, timeout); end
        step();
        checks++; if (grant !== 4'b0000 || load !== 1'b0 || timeout !== 1'b1) begin errors++; $display("FAIL to_expire got=%b/%b/%b want=0000/0/1", grant, load, timeout); end
        req = 4'b1111;
        step();
        checks++; if (timeout !== 1'b0 || grant !== 4'b0010) begin errors++; $display("FAIL to_next got=%b/%b want=0/0010", timeout, grant); end
        req = 4'b0000;
        step(); step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (grant !== 4'b0000 || timeout !== 1'b0) begin errors++; $display("FAIL to_ack_wins got=%b/%b want=0000/0", grant, timeout); end
        req = 4'b1111;
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL to_ptr_after_ack got=%b want=0100", grant); end
        ack = 1'b1; req = 4'b0000; step(); ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_hold();
        test_ack_idle();
        test_reset_mid_wait();
        test_back_to_back();
`ifdef RR_GRANT_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_grant_gen.md
# rr_grant_gen

Round-robin grant generator for a WIDTH-requester arbiter. It samples the request vector, selects one requester fairly, and presents a registered one-hot grant with a load strobe. The strobe and grant are held until the downstream grant register accepts them with ack. It sits directly upstream of the grant register: `grant` drives that register's `in`, and `load` drives its `load`. The register captures on `load & ack`.

## Interface
- WIDTH, 4: number of requesters (≥2); width of req/grant.
- TIMEOUT, 15: cycles to wait for ack before abandoning a grant (used only with RR_GRANT_TIMEOUT_EN; ≥1).
- clk  input  1  single clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- req  input  WIDTH  request vector, bit i = requester i.
- ack  input  1  downstream accepted current grant.
- grant  output  WIDTH  registered one-hot grant, all-zero when none.
- load  output  1  grant valid; high exactly while a grant is outstanding.
- timeout  output  1  one-cycle pulse when a grant is abandoned (constant 0 without macro).

## Operation
- Reset (rst low, async):
  - grant=0, load=0, timeout=0.
  - state=IDLE.
  - last-grant pointer ptr=WIDTH-1, so the first search starts at bit 0.
  - Timeout counter cleared.
- ptr: log2(WIDTH)-bit index of the most recently completed grant.
- Selection: the first set bit of req, searching upward from ptr+1 and wrapping modulo WIDTH. ptr itself is searched last. The result is always one-hot.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise: register the selected one-hot into grant, set load=1, go to WAIT.
  - ack in IDLE is ignored.
- WAIT:
  - grant and load are held constant regardless of req changes. A requester dropping its req does not withdraw its grant.
  - ack=1: ptr←index(grant), grant←0, load←0, go to IDLE.
- No other states. Illegal state encodings recover to IDLE with grant=0.

## Timing
- Request-to-grant latency: req sampled at edge t in IDLE, so grant/load are valid after edge t.
- Handshake:
  - The downstream register captures grant on the same edge at which ack is sampled high in WAIT.
  - After that edge, load=0 and grant=0.
- Back-to-back grants:
  - At least one cycle with load=0 separates consecutive grants. ack at edge t gives IDLE after t, so the earliest next grant is after t+1.
  - Maximum throughput is one grant per 2 cycles.
- Fairness: with all WIDTH requesters continuously asserting, each receives exactly one grant per WIDTH grants.
- Reset mid-WAIT: the grant is dropped immediately (async), ptr returns to WIDTH-1, and no ack is required.

## Configuration
- RR_GRANT_TIMEOUT_EN defined:
  - A counter (width ≥ log2(TIMEOUT+1)) clears on entry to WAIT and increments each WAIT cycle with ack=0.
  - When the counter reaches TIMEOUT with ack=0:
    - grant←0, load←0.
    - ptr←index(abandoned grant), so the stalled requester moves to lowest priority.
    - timeout pulses high for one cycle.
    - State goes to IDLE.
  - ack sampled high on the same edge as expiry wins: normal completion, no timeout pulse.
- RR_GRANT_TIMEOUT_EN undefined:
  - No counter is built.
  - WAIT lasts indefinitely until ack.
  - timeout is tied to 0.

## Test plan
- Reset, then req=4'b1111 held, ack pulsed one cycle after each load rise -> grants in order 0001, 0010, 0100, 1000, 0001, with load low for one cycle between grants.
- After a completed grant of 0001 (ptr=0), req=4'b1001 -> grant 1000; after ack, grant 0001 (wrap-around).
- Grant 0010 outstanding, ack low for 6 cycles while req changes 0010→0001→0000 -> grant stays 0010 and load stays 1 throughout; ack -> grant 0, IDLE.
- ack held high in IDLE with req=0 for 5 cycles -> grant=0, load=0, ptr unchanged; next req=0100 -> grant 0100.
- Assert rst low while grant=0100 in WAIT -> grant=0 and load=0 immediately; after release, req=1111 -> grant 0001.
- With RR_GRANT_TIMEOUT_EN and TIMEOUT=3: grant 0001, no ack -> after 3 WAIT cycles, timeout pulses one cycle and grant=0; req=1111 -> next grant 0010. A second run with ack on the expiry edge -> no timeout pulse, normal completion.
